// File: rtl/tile_mac_engine.sv
// Output-stationary ROWxCOL tile multiplier: dual req/grant operand load, COL MAC lanes, chained partial sums.
// Define TILE_MAC_SAT_EN to saturate written results to signed WIDTH range instead of wrapping.
module tile_mac_engine #(
  parameter int WIDTH   = 32,
  parameter int ROW     = 4,
  parameter int COL     = 4,
  parameter int KDEPTH  = 12,
  parameter int I_INDEX = 0,
  parameter int J_INDEX = 0,
  parameter int K_INDEX = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     acc_mode,
  input  logic                     grant_in,
  input  logic                     grant_w,
  input  logic [WIDTH-1:0]         data_in_a,
  input  logic [WIDTH-1:0]         data_in_b,
  input  logic [ROW*COL*WIDTH-1:0] result_in,
  output logic                     req_in,
  output logic                     req_w,
  output logic                     busy,
  output logic                     done,
  output logic [ROW*COL*WIDTH-1:0] result_out,
  output logic [7:0]               i,
  output logic [7:0]               j,
  output logic [7:0]               k
);

  localparam int NA   = ROW * KDEPTH;
  localparam int NB   = KDEPTH * COL;
  localparam int ACCW = 2 * WIDTH + $clog2(KDEPTH) + 1;
  localparam int CAW  = $clog2(NA + 1);
  localparam int CBW  = $clog2(NB + 1);
  localparam int AIW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int BIW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int KW   = (KDEPTH > 1) ? $clog2(KDEPTH) : 1;

`ifdef TILE_MAC_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;

  state_t                   state_q;
  logic                     accMode_q;
  logic                     reqA_q;
  logic                     reqB_q;
  logic                     busy_q;
  logic                     done_q;
  logic [CAW-1:0]           cntA_q;
  logic [CBW-1:0]           cntB_q;
  logic [RW-1:0]            rowIdx_q;
  logic [KW-1:0]            kIdx_q;
  logic signed [WIDTH-1:0]  aBuf_q [NA];
  logic signed [WIDTH-1:0]  bBuf_q [NB];
  logic signed [ACCW-1:0]   acc_q [ROW][COL];
  logic [ROW*COL*WIDTH-1:0] result_q;
  logic [ROW*COL*WIDTH-1:0] wrData_d;
  logic signed [2*WIDTH-1:0] prod_d [COL];
  logic                     capA_d;
  logic                     capB_d;
  logic                     lastA_d;
  logic                     lastB_d;
  logic                     aComplete_d;
  logic                     bComplete_d;
  logic                     lastStep_d;
  logic [AIW-1:0]           aIdx_d;

  // A word is only taken while its own request is still up, so late grants are harmless.
  assign capA_d      = reqA_q & grant_in;
  assign capB_d      = reqB_q & grant_w;
  assign lastA_d     = capA_d && (cntA_q == CAW'(NA - 1));
  assign lastB_d     = capB_d && (cntB_q == CBW'(NB - 1));
  assign aComplete_d = (cntA_q == CAW'(NA)) || lastA_d;
  assign bComplete_d = (cntB_q == CBW'(NB)) || lastB_d;
  assign lastStep_d  = (rowIdx_q == RW'(ROW - 1)) && (kIdx_q == KW'(KDEPTH - 1));
  assign aIdx_d      = AIW'(int'(rowIdx_q) * KDEPTH + int'(kIdx_q));

  always_ff @(posedge clk) begin
    if (capA_d) aBuf_q[cntA_q[AIW-1:0]] <= data_in_a;
    if (capB_d) bBuf_q[cntB_q[BIW-1:0]] <= data_in_b;
  end

  always_comb begin
    for (int cc = 0; cc < COL; cc++) begin
      prod_d[cc] = (2*WIDTH)'(aBuf_q[aIdx_d]) *
                   (2*WIDTH)'(bBuf_q[BIW'(int'(kIdx_q) * COL + cc)]);
    end
  end

  always_comb begin
    wrData_d = '0;
    for (int rr = 0; rr < ROW; rr++) begin
      for (int cc = 0; cc < COL; cc++) begin
`ifdef TILE_MAC_SAT_EN
        if (acc_q[rr][cc] > SAT_MAX)
          wrData_d[(rr*COL+cc)*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
        else if (acc_q[rr][cc] < SAT_MIN)
          wrData_d[(rr*COL+cc)*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
        else
          wrData_d[(rr*COL+cc)*WIDTH +: WIDTH] = acc_q[rr][cc][WIDTH-1:0];
`else
        wrData_d[(rr*COL+cc)*WIDTH +: WIDTH] = acc_q[rr][cc][WIDTH-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      accMode_q <= 1'b0;
      reqA_q    <= 1'b0;
      reqB_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cntA_q    <= '0;
      cntB_q    <= '0;
      rowIdx_q  <= '0;
      kIdx_q    <= '0;
      result_q  <= '0;
      for (int rr = 0; rr < ROW; rr++) begin
        for (int cc = 0; cc < COL; cc++) begin
          acc_q[rr][cc] <= '0;
        end
      end
    end else begin
      if (capA_d) cntA_q <= cntA_q + CAW'(1);
      if (capB_d) cntB_q <= cntB_q + CBW'(1);
      if (lastA_d) reqA_q <= 1'b0;
      if (lastB_d) reqB_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (en) begin
            state_q   <= LOAD;
            accMode_q <= acc_mode;
            cntA_q    <= '0;
            cntB_q    <= '0;
            reqA_q    <= 1'b1;
            reqB_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (aComplete_d && bComplete_d) begin
            state_q  <= COMPUTE;
            rowIdx_q <= '0;
            kIdx_q   <= '0;
            for (int rr = 0; rr < ROW; rr++) begin
              for (int cc = 0; cc < COL; cc++) begin
                acc_q[rr][cc] <= accMode_q ?
                  ACCW'($signed(result_in[(rr*COL+cc)*WIDTH +: WIDTH])) : '0;
              end
            end
          end
        end
        COMPUTE: begin
          for (int cc = 0; cc < COL; cc++) begin
            acc_q[rowIdx_q][cc] <= acc_q[rowIdx_q][cc] + ACCW'(prod_d[cc]);
          end
          if (kIdx_q == KW'(KDEPTH - 1)) begin
            kIdx_q   <= '0;
            rowIdx_q <= rowIdx_q + RW'(1);
          end else begin
            kIdx_q <= kIdx_q + KW'(1);
          end
          if (lastStep_d) state_q <= WRITE;
        end
        WRITE: begin
          result_q <= wrData_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_in     = reqA_q;
  assign req_w      = reqB_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = result_q;
  assign i          = 8'(I_INDEX);
  assign j          = 8'(J_INDEX);
  assign k          = 8'(K_INDEX);

endmodule

// File: tb/tb_tile_mac_engine.sv
// Directed bench for tile_mac_engine: default-size tile plus an 8-bit instance for the wrap/saturate result.
module tb_tile_mac_engine;

  localparam int WIDTH  = 32;
  localparam int ROW    = 4;
  localparam int COL    = 4;
  localparam int KDEPTH = 12;
  localparam int NA     = ROW * KDEPTH;
  localparam int NB     = KDEPTH * COL;
  localparam int TW     = ROW * COL * WIDTH;
  localparam int TW8    = ROW * COL * 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             accMode;
  logic             grantA;
  logic             grantB;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [TW-1:0]    resultIn;
  logic [TW-1:0]    resultOut;
  logic             reqA;
  logic             reqB;
  logic             busy;
  logic             done;
  logic [7:0]       iIdx;
  logic [7:0]       jIdx;
  logic [7:0]       kIdx;

  logic             en8;
  logic             reqA8;
  logic             reqB8;
  logic             busy8;
  logic             done8;
  logic [TW8-1:0]   resultOut8;
  logic [7:0]       iIdx8;
  logic [7:0]       jIdx8;
  logic [7:0]       kIdx8;

  logic [WIDTH-1:0] aMat [NA];
  logic [WIDTH-1:0] bMat [NB];
  logic [TW-1:0]    expIdent;
  logic [TW-1:0]    expAcc;
  logic [TW-1:0]    expNeg;
  logic [TW8-1:0]   expSmall;

  int assertCount = 0;
  int failCount   = 0;

  tile_mac_engine #(
    .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .KDEPTH(KDEPTH),
    .I_INDEX(3), .J_INDEX(5), .K_INDEX(7)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .acc_mode(accMode),
    .grant_in(grantA), .grant_w(grantB),
    .data_in_a(dataA), .data_in_b(dataB), .result_in(resultIn),
    .req_in(reqA), .req_w(reqB), .busy(busy), .done(done),
    .result_out(resultOut), .i(iIdx), .j(jIdx), .k(kIdx)
  );

  tile_mac_engine #(
    .WIDTH(8), .ROW(ROW), .COL(COL), .KDEPTH(KDEPTH),
    .I_INDEX(0), .J_INDEX(0), .K_INDEX(0)
  ) dut8 (
    .clk(clk), .rst(rst), .en(en8), .acc_mode(1'b0),
    .grant_in(1'b1), .grant_w(1'b1),
    .data_in_a(8'd127), .data_in_b(8'd127), .result_in({TW8{1'b0}}),
    .req_in(reqA8), .req_w(reqB8), .busy(busy8), .done(done8),
    .result_out(resultOut8), .i(iIdx8), .j(jIdx8), .k(kIdx8)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkTile(input string tag, input logic [TW-1:0] observed, input logic [TW-1:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Grants follow a fixed period and stay asserted after the requests drop; words go out in order.
  task automatic feedCycle(input int cyc, input int gaP, input int gbP, inout int aSent, inout int bSent);
    grantA = (cyc % gaP) == 0;
    grantB = (cyc % gbP) == 0;
    if (grantA && reqA && aSent < NA) begin
      dataA = aMat[aSent];
      aSent++;
    end else begin
      dataA = 32'hDEAD_BEEF;
    end
    if (grantB && reqB && bSent < NB) begin
      dataB = bMat[bSent];
      bSent++;
    end else begin
      dataB = 32'hBAD0_F00D;
    end
  endtask

  // Cycle 1 is the cycle after the edge that samples en; done is expected in cycle expDone.
  task automatic applyStimulus(input string name, input int gaP, input int gbP, input bit accM,
                               input bit pulseEn, input int expDone,
                               input logic [TW-1:0] holdTile, input logic [TW-1:0] expTile);
    int aSent = 0;
    int bSent = 0;
    int doneCycle = -1;
    int doneCount = 0;
    @(negedge clk);
    en = 1'b1;
    accMode = accM;
    for (int cyc = 1; cyc <= expDone + 3; cyc++) begin
      @(negedge clk);
      en = 1'b0;
      accMode = 1'b0;
      if (cyc == 1) begin
        checkOutput({name, "/req_in_rise"}, 64'(reqA), 64'd1);
        checkOutput({name, "/req_w_rise"}, 64'(reqB), 64'd1);
        checkOutput({name, "/busy_rise"}, 64'(busy), 64'd1);
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (cyc == expDone - 1) checkTile({name, "/result_hold"}, resultOut, holdTile);
      if (cyc == expDone) begin
        checkTile({name, "/result"}, resultOut, expTile);
        checkOutput({name, "/busy_at_done"}, 64'(busy), 64'd1);
      end
      if (cyc == expDone + 1) checkOutput({name, "/busy_after_done"}, 64'(busy), 64'd0);
      if (pulseEn && (cyc == 10 || cyc == 70 || cyc == expDone)) en = 1'b1;
      feedCycle(cyc, gaP, gbP, aSent, bSent);
    end
    checkOutput({name, "/done_cycle"}, 64'(doneCycle), 64'(expDone));
    checkOutput({name, "/done_count"}, 64'(doneCount), 64'd1);
    checkOutput({name, "/req_in_idle"}, 64'(reqA), 64'd0);
    checkOutput({name, "/busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic runSmall();
    int doneCycle = -1;
    @(negedge clk);
    en8 = 1'b1;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(negedge clk);
      en8 = 1'b0;
      if (done8 && doneCycle < 0) begin
        doneCycle = cyc;
        checkTile("w8/result", TW'(resultOut8), TW'(expSmall));
      end
    end
    checkOutput("w8/done_cycle", 64'(doneCycle), 64'd98);
  endtask

  initial begin
    int aSent;
    int bSent;
    int doneCount;

    rst = 1'b1; en = 1'b0; en8 = 1'b0; accMode = 1'b0;
    grantA = 1'b0; grantB = 1'b0; dataA = '0; dataB = '0; resultIn = '0;

    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        expIdent[(r*COL+c)*WIDTH +: WIDTH] = 32'(r * COL + c);
        expAcc[(r*COL+c)*WIDTH +: WIDTH]   = 32'(100 + r * COL + c);
        expNeg[(r*COL+c)*WIDTH +: WIDTH]   = 32'(-(264 + 12 * c));
`ifdef TILE_MAC_SAT_EN
        expSmall[(r*COL+c)*8 +: 8] = 8'd127;
`else
        expSmall[(r*COL+c)*8 +: 8] = 8'd12;
`endif
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("reset/req_in", 64'(reqA), 64'd0);
    checkOutput("reset/busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset/req_w", 64'(reqB), 64'd0);
    checkOutput("reset/done", 64'(done), 64'd0);
    checkTile("reset/result", resultOut, '0);
    checkOutput("index/i", 64'(iIdx), 64'd3);
    checkOutput("index/j", 64'(jIdx), 64'd5);
    checkOutput("index/k", 64'(kIdx), 64'd7);

    // Identity-padded A against sequential B.
    for (int n = 0; n < NA; n++) aMat[n] = ((n / KDEPTH) == (n % KDEPTH)) ? 32'd1 : 32'd0;
    for (int n = 0; n < NB; n++) bMat[n] = 32'(n);
    // Continuous grants: last word at edge 48, done in cycle 48 + 2 + 48.
    applyStimulus("ident", 1, 1, 1'b0, 1'b0, 98, '0, expIdent);

    for (int n = 0; n < ROW * COL; n++) resultIn[n*WIDTH +: WIDTH] = 32'd100;
    applyStimulus("accum", 1, 1, 1'b1, 1'b0, 98, expIdent, expAcc);

    // A granted every third cycle: last A word at edge 144.
    applyStimulus("sparseA", 3, 1, 1'b0, 1'b0, 194, expAcc, expIdent);

    // A all -1, B granted every other cycle so B finishes last at edge 96.
    for (int n = 0; n < NA; n++) aMat[n] = 32'hFFFF_FFFF;
    applyStimulus("negB2", 1, 2, 1'b0, 1'b0, 146, expIdent, expNeg);

    for (int n = 0; n < NA; n++) aMat[n] = ((n / KDEPTH) == (n % KDEPTH)) ? 32'd1 : 32'd0;
    applyStimulus("enPulse", 1, 1, 1'b0, 1'b1, 98, expNeg, expIdent);

    // Abort in the middle of COMPUTE.
    aSent = 0;
    bSent = 0;
    @(negedge clk);
    en = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      en = 1'b0;
      feedCycle(cyc, 1, 1, aSent, bSent);
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort/req_in", 64'(reqA), 64'd0);
    checkOutput("abort/req_w", 64'(reqB), 64'd0);
    checkOutput("abort/busy", 64'(busy), 64'd0);
    checkOutput("abort/done", 64'(done), 64'd0);
    checkTile("abort/result", resultOut, '0);
    rst = 1'b0;
    doneCount = 0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort/no_done", 64'(doneCount), 64'd0);
    checkOutput("abort/busy_idle", 64'(busy), 64'd0);

    applyStimulus("afterAbort", 1, 1, 1'b0, 1'b0, 98, '0, expIdent);

    runSmall();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
